// File: rtl/interboard_pkg.sv
// Shared definitions for the inter-board link: word format and the
// receiver FIFO geometry that the transmit-side flow control must respect.
package interboard_pkg;

  localparam int DATA_W         = 11;
  localparam int FIFO_DEPTH     = 256;
  localparam int RX_STOP_LEVEL  = 240;
  localparam int RX_START_LEVEL = 239;
  localparam int RX_HEADROOM    = FIFO_DEPTH - RX_STOP_LEVEL;

  typedef logic [DATA_W-1:0] link_word_t;

endpackage

// File: rtl/interboard_tx_sync_bit.sv
// N-flop single-bit synchroniser with asynchronous reset to 0.
// Reusable for any slow control line arriving from the far board.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/interboard_tx.sv
// Transmit stage of the inter-board link: drains the outbound FIFO onto the
// link under the receiver's synchronised read flow control.
module interboard_tx
  import interboard_pkg::*;
#(
  parameter int DATA_W         = interboard_pkg::DATA_W,
  parameter int SYNC_STAGES    = 2,
  parameter int STARTUP_CYCLES = 16
) (
  input  logic              transmit_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  input  logic              read,
  output logic [DATA_W-1:0] send_data,
  output logic              valid,
  output logic              stalled,
  output logic [15:0]       words_sent
);

  // Words still in flight after read drops must fit the receiver headroom.
  if (SYNC_STAGES + 1 >= RX_HEADROOM) begin : g_headroom_check
    $error("interboard_tx: SYNC_STAGES too large for receiver headroom");
  end
  if (SYNC_STAGES < 2) begin : g_sync_check
    $error("interboard_tx: SYNC_STAGES must be at least 2");
  end
  if (STARTUP_CYCLES < 1) begin : g_startup_check
    $error("interboard_tx: STARTUP_CYCLES must be at least 1");
  end

  localparam int CNT_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARTUP_CYCLES - 1);

  typedef enum logic [1:0] {
    STARTUP,
    HOLD,
    SEND
  } tx_state_t;

  tx_state_t        state;
  tx_state_t        next_state;
  logic [CNT_W-1:0] startup_cnt;
  logic             rd_pend;
  logic             read_s;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_read_sync (
    .clk  (transmit_clk),
    .reset(reset),
    .d    (read),
    .q    (read_s)
  );

  always_comb begin
    next_state = state;
    case (state)
      STARTUP: if (startup_cnt == CNT_LAST) next_state = HOLD;
      HOLD:    if (read_s)                  next_state = SEND;
      SEND:    if (!read_s)                 next_state = HOLD;
      default:                              next_state = STARTUP;
    endcase
  end

  assign fifo_rdreq = (state == SEND) && read_s && !fifo_empty;

  always_ff @(posedge transmit_clk or posedge reset) begin
    if (reset) begin
      state       <= STARTUP;
      startup_cnt <= '0;
      rd_pend     <= 1'b0;
      send_data   <= '0;
      valid       <= 1'b0;
      stalled     <= 1'b0;
      words_sent  <= '0;
    end else begin
      state <= next_state;
      if (state == STARTUP && startup_cnt != CNT_LAST)
        startup_cnt <= startup_cnt + CNT_W'(1);
      // FIFO is normal-mode: data for an accepted request appears one cycle later.
      rd_pend <= fifo_rdreq;
      valid   <= rd_pend;
      if (rd_pend)
        send_data <= fifo_q;
      stalled <= (next_state == HOLD) && !fifo_empty;
      if (valid)
        words_sent <= words_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_interboard_tx.sv
// Directed bench for interboard_tx with a FIFO model and an output scoreboard.
module tb_interboard_tx;

  logic        transmit_clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] fifo_q = '0;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic        read = 1'b0;
  logic [10:0] send_data;
  logic        valid;
  logic        stalled;
  logic [15:0] words_sent;

  int total = 0;
  int bad = 0;
  int outs = 0;

  logic [10:0] mem [0:511];
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [10:0] sb [$];

  always #5 transmit_clk = ~transmit_clk;

  interboard_tx #(
    .DATA_W(11),
    .SYNC_STAGES(2),
    .STARTUP_CYCLES(16)
  ) dut (
    .transmit_clk(transmit_clk),
    .reset(reset),
    .fifo_q(fifo_q),
    .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq),
    .read(read),
    .send_data(send_data),
    .valid(valid),
    .stalled(stalled),
    .words_sent(words_sent)
  );

  // Normal-mode FIFO: q updates on the edge that accepts the request.
  assign fifo_empty = (wr_cnt == rd_cnt);
  always @(posedge transmit_clk) begin
    if (fifo_rdreq && !fifo_empty) begin
      fifo_q <= mem[rd_cnt[8:0]];
      rd_cnt <= rd_cnt + 1;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [10:0] w);
    mem[wr_cnt[8:0]] = w;
    wr_cnt++;
    sb.push_back(w);
  endtask

  task automatic tick();
    logic [10:0] exp;
    @(negedge transmit_clk);
    chk("rdreq_when_empty", {31'd0, fifo_rdreq & fifo_empty}, 32'd0);
    if (valid === 1'b1) begin
      outs++;
      chk("sb_has_word", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("data_order", {21'd0, send_data}, {21'd0, exp});
      end
    end
  endtask

  task automatic wait_valid(input int limit, input string tag);
    int n = 0;
    while (valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, valid}, 32'd1);
  endtask

  task automatic drain(input int limit, input string tag);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    chk(tag, sb.size(), 32'd0);
  endtask

  task automatic check_startup(input string tag);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk({tag, "_rdreq"}, {31'd0, fifo_rdreq}, 32'd0);
      chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    end
  endtask

  initial begin
    int n_after;
    int pend;

    // Reset state and startup hold with five queued words
    read = 1'b1;
    for (int i = 0; i < 5; i++) push(11'h101 + 11'(i));
    repeat (3) @(negedge transmit_clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_send_data", {21'd0, send_data}, 32'd0);
    chk("rst_stalled", {31'd0, stalled}, 32'd0);
    chk("rst_words_sent", {16'd0, words_sent}, 32'd0);
    chk("rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    reset = 1'b0;
    check_startup("startup");
    wait_valid(20, "first_valid");
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("five_burst", {31'd0, valid}, (k < 5) ? 32'd1 : 32'd0);
    end
    repeat (2) tick();
    chk("words_sent_5", {16'd0, words_sent}, 32'd5);
    chk("send_empty_stalled", {31'd0, stalled}, 32'd0);
    chk("five_drained", sb.size(), 32'd0);

    // Back-to-back stream 0x001..0x100
    for (int i = 1; i <= 256; i++) push(11'(i));
    wait_valid(10, "stream_start");
    for (int k = 1; k < 256; k++) begin
      tick();
      chk("stream_gap", {31'd0, valid}, 32'd1);
    end
    tick();
    chk("stream_end", {31'd0, valid}, 32'd0);
    chk("stream_drained", sb.size(), 32'd0);

    // read dropped mid-stream
    for (int i = 0; i < 40; i++) push(11'h200 + 11'(i));
    wait_valid(10, "drop_start");
    repeat (5) tick();
    read = 1'b0;
    n_after = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (valid === 1'b1) n_after++;
      if (k >= 4) chk("drop_valid_late", {31'd0, valid}, 32'd0);
    end
    chk("drop_count_le3", {31'd0, n_after <= 3}, 32'd1);
    chk("drop_stalled", {31'd0, stalled}, 32'd1);
    chk("drop_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    read = 1'b1;
    drain(200, "drop_resume_drain");
    repeat (3) tick();
    chk("drop_fifo_empty", {31'd0, fifo_empty}, 32'd1);

    // FIFO runs empty in SEND between single words
    for (int i = 0; i < 6; i++) begin
      push(11'h300 + 11'(i));
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("trickle_valid", {31'd0, valid}, (k == 1) ? 32'd1 : 32'd0);
        chk("trickle_stalled", {31'd0, stalled}, 32'd0);
      end
    end
    chk("trickle_drained", sb.size(), 32'd0);

    // Reset while a word is pending
    for (int i = 0; i < 20; i++) push(11'h400 + 11'(i));
    wait_valid(10, "rstmid_start");
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("rstmid_valid", {31'd0, valid}, 32'd0);
    chk("rstmid_send_data", {21'd0, send_data}, 32'd0);
    chk("rstmid_stalled", {31'd0, stalled}, 32'd0);
    chk("rstmid_words_sent", {16'd0, words_sent}, 32'd0);
    chk("rstmid_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    pend = rd_cnt - outs;
    chk("rstmid_pending", pend, 32'd1);
    for (int i = 0; i < pend; i++) void'(sb.pop_front());
    repeat (2) tick();
    reset = 1'b0;
    check_startup("restart");
    wait_valid(20, "restart_valid");
    drain(100, "restart_drain");

    // words_sent wrap: 65537 words after a clean reset
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("wrap_rst_count", {16'd0, words_sent}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      push(11'(i));
      tick();
    end
    drain(100, "wrap_drain");
    repeat (3) tick();
    chk("wrap_words_sent", {16'd0, words_sent}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
